// File: rtl/demux_dataless_pkg.sv
// demux_dataless shared definitions.
// DEMUX_INDEX_CHECK_EN: stall on out-of-range index, add sticky index_err.
package demux_dataless_pkg;

  localparam int DEMUX_SELECT_DEFAULT = 2;

  // Narrowest index able to address size outputs
  function automatic int sel_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/demux_slot_dataless.sv
// demux_dataless single-token output slot.
// A draining slot may be refilled in the same cycle.
module demux_slot_dataless (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic outs_valid,
  input  logic outs_ready,
  output logic free
);

  logic full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (outs_ready) begin
      full <= 1'b0;
    end
  end

  assign outs_valid = full;
  assign free       = ~full | outs_ready;

endmodule

// File: rtl/demux_dataless.sv
// demux_dataless: joins a dataless token with an index, routes to a slot.
// DEMUX_INDEX_CHECK_EN: out-of-range index stalls and sets index_err.
module demux_dataless
  import demux_dataless_pkg::*;
#(
  parameter int SIZE        = 2,
  parameter int SELECT_TYPE = DEMUX_SELECT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ins_valid,
  output logic                   ins_ready,
  input  logic [SELECT_TYPE-1:0] index,
  input  logic                   index_valid,
  output logic                   index_ready,
  output logic [SIZE-1:0]        outs_valid,
  input  logic [SIZE-1:0]        outs_ready
`ifdef DEMUX_INDEX_CHECK_EN
  ,
  output logic                   index_err
`endif
);

  localparam int NPAD = 2**SELECT_TYPE;

`ifdef DEMUX_INDEX_CHECK_EN
  localparam logic OOR_FREE = 1'b0;
`else
  localparam logic OOR_FREE = 1'b1;
`endif

  logic [SIZE-1:0] free;
  logic [SIZE-1:0] load;
  logic [NPAD-1:0] free_pad;
  logic            sel_free;
  logic            fire;

  // Unused index codes read as always-free (discard) or never-free (stall)
  for (genvar k = 0; k < NPAD; k++) begin : g_pad
    if (k < SIZE) begin : g_real
      assign free_pad[k] = free[k];
    end else begin : g_oor
      assign free_pad[k] = OOR_FREE;
    end
  end

  assign sel_free    = free_pad[index];
  assign ins_ready   = index_valid & sel_free;
  assign index_ready = ins_valid & sel_free;
  assign fire        = ins_valid & index_valid & sel_free;

  for (genvar k = 0; k < SIZE; k++) begin : g_slot
    assign load[k] = fire & (index == SELECT_TYPE'(k));

    demux_slot_dataless u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (load[k]),
      .outs_valid (outs_valid[k]),
      .outs_ready (outs_ready[k]),
      .free       (free[k])
    );
  end

`ifdef DEMUX_INDEX_CHECK_EN
  logic in_range;

  assign in_range = 32'(index) < SIZE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_err <= 1'b0;
    end else if (index_valid & ~in_range) begin
      index_err <= 1'b1;
    end
  end
`endif

endmodule
